// File: rtl/aq_gemac_rx_frame.sv
// aq_gemac_rx_frame
// Receive framer behind the GMII input buffer (rx_clk domain). Strips the
// preamble and SFD. Checks the CRC-32 residue and holds back the 4 FCS bytes
// in a 5-deep delay line. Emits frame bytes with sof/eof markers and one
// status strobe per frame.
module aq_gemac_rx_frame #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        rx_clk,
  input  logic        rst_b,
  input  logic [7:0]  bgmii_rxd,
  input  logic        bgmii_rxe,
  input  logic        bgmii_rxer,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_sof,
  output logic        rx_eof,
  output logic        rx_stat_valid,
  output logic [15:0] rx_len,
  output logic        rx_crc_err,
  output logic        rx_len_err,
  output logic        rx_phy_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_DATA, ST_DROP} state_t;

  localparam logic [15:0] MIN_LEN_W = 16'(MIN_LEN);
  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

  // One byte of the reflected CRC-32 (LSB first), no final inversion.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 32'hEDB88320;
      else             c = c >> 1;
    end
    return c;
  endfunction

  // Bit reversal so the LSB-first register can be compared with the
  // MSB-first residue constant.
  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  state_t      r_state;
  logic [7:0]  r_dl [0:4];   // [0] newest, [4] oldest
  logic [2:0]  r_cnt;        // bytes held in the delay line, saturates at 5
  logic [15:0] r_len;
  logic [31:0] r_crc;
  logic        r_phy;
  logic        r_first;      // next emitted byte is the frame's first

  logic        w_enter_data;
  logic        w_crc_good;
  logic        w_len_err;

  assign w_enter_data = bgmii_rxe && (bgmii_rxd == 8'hD5) &&
                        ((r_state == ST_IDLE) || (r_state == ST_PRE));
  assign w_crc_good   = (bitrev32(r_crc) == 32'hC704DD7B);
  assign w_len_err    = (r_len < MIN_LEN_W) || (r_len > MAX_LEN_W);

  // Framing FSM, delay line, CRC/length tracking and all registered outputs.
  always_ff @(posedge rx_clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state       <= ST_IDLE;
      for (int i = 0; i < 5; i++) r_dl[i] <= 8'h00;
      r_cnt         <= 3'd0;
      r_len         <= 16'd0;
      r_crc         <= 32'hFFFFFFFF;
      r_phy         <= 1'b0;
      r_first       <= 1'b0;
      rx_data       <= 8'h00;
      rx_valid      <= 1'b0;
      rx_sof        <= 1'b0;
      rx_eof        <= 1'b0;
      rx_stat_valid <= 1'b0;
      rx_len        <= 16'd0;
      rx_crc_err    <= 1'b0;
      rx_len_err    <= 1'b0;
      rx_phy_err    <= 1'b0;
    end else begin
      rx_valid      <= 1'b0;
      rx_sof        <= 1'b0;
      rx_eof        <= 1'b0;
      rx_stat_valid <= 1'b0;

      // Per-frame state starts clean whenever an SFD is accepted.
      if (w_enter_data) begin
        for (int i = 0; i < 5; i++) r_dl[i] <= 8'h00;
        r_cnt   <= 3'd0;
        r_len   <= 16'd0;
        r_crc   <= 32'hFFFFFFFF;
        r_phy   <= 1'b0;
        r_first <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (bgmii_rxe) begin
            if (bgmii_rxd == 8'h55)      r_state <= ST_PRE;
            else if (bgmii_rxd == 8'hD5) r_state <= ST_DATA;
            else                         r_state <= ST_DROP;
          end
        end
        ST_PRE: begin
          if (!bgmii_rxe)              r_state <= ST_IDLE;
          else if (bgmii_rxd == 8'h55) r_state <= ST_PRE;
          else if (bgmii_rxd == 8'hD5) r_state <= ST_DATA;
          else                         r_state <= ST_DROP;
        end
        ST_DATA: begin
          if (bgmii_rxe) begin
            if (r_cnt == 3'd5) begin
              rx_data  <= r_dl[4];
              rx_valid <= 1'b1;
              rx_sof   <= r_first;
              r_first  <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 3'd1;
            end
            for (int i = 4; i > 0; i--) r_dl[i] <= r_dl[i-1];
            r_dl[0] <= bgmii_rxd;
            r_crc   <= crc32_byte(r_crc, bgmii_rxd);
            if (r_len != 16'hFFFF) r_len <= r_len + 16'd1;
            if (bgmii_rxer) r_phy <= 1'b1;
          end else begin
            // End of frame: last payload byte (if any) plus status; FCS dropped.
            if (r_cnt == 3'd5) begin
              rx_data  <= r_dl[4];
              rx_valid <= 1'b1;
              rx_sof   <= r_first;
              rx_eof   <= 1'b1;
            end
            if (r_cnt != 3'd0) begin
              rx_stat_valid <= 1'b1;
              rx_len        <= r_len;
              rx_crc_err    <= ~w_crc_good;
              rx_len_err    <= w_len_err;
              rx_phy_err    <= r_phy;
            end
            r_state <= ST_IDLE;
          end
        end
        ST_DROP: begin
          if (!bgmii_rxe) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aq_gemac_rx_frame.sv
// Directed bench for aq_gemac_rx_frame: frame-level model with an expected
// byte queue and an expected status queue, one compare process on negedge.
module tb_aq_gemac_rx_frame;

  logic        rx_clk = 1'b0;
  logic        rst_b;
  logic [7:0]  bgmii_rxd;
  logic        bgmii_rxe;
  logic        bgmii_rxer;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_sof, rx_eof, rx_stat_valid;
  logic [15:0] rx_len;
  logic        rx_crc_err, rx_len_err, rx_phy_err;

  aq_gemac_rx_frame #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
    .rx_clk(rx_clk), .rst_b(rst_b),
    .bgmii_rxd(bgmii_rxd), .bgmii_rxe(bgmii_rxe), .bgmii_rxer(bgmii_rxer),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_eof(rx_eof),
    .rx_stat_valid(rx_stat_valid), .rx_len(rx_len), .rx_crc_err(rx_crc_err),
    .rx_len_err(rx_len_err), .rx_phy_err(rx_phy_err)
  );

  always #5 rx_clk = ~rx_clk;

  typedef logic [7:0] bq_t[$];
  typedef struct packed { logic [7:0] d; logic sof; logic eof; } dexp_t;
  typedef struct packed { logic [15:0] len; logic crc; logic le; logic phy; } sexp_t;

  dexp_t exp_d[$];
  sexp_t exp_s[$];
  int errors = 0;
  int checks = 0;
  int n_data = 0;
  int n_stat = 0;
  logic [15:0] last_len = 16'd0;
  logic last_crc = 1'b0, last_le = 1'b0, last_phy = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Standard Ethernet CRC-32 (with final inversion) over the first n bytes.
  function automatic logic [31:0] crc32_std(input bq_t q, input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, q[i]};
      repeat (8) c = (c >> 1) ^ (c[0] ? 32'hEDB88320 : 32'h0);
    end
    return ~c;
  endfunction

  function automatic bq_t mk_frame(input bq_t p);
    bq_t f;
    logic [31:0] c;
    f = p;
    c = crc32_std(p, p.size());
    f.push_back(c[7:0]);  f.push_back(c[15:8]);
    f.push_back(c[23:16]); f.push_back(c[31:24]);
    return f;
  endfunction

  // What the framer must produce for a frame whose post-SFD bytes are body.
  task automatic model_push(input bq_t body, input int er_idx);
    int n;
    sexp_t s;
    logic [31:0] fcs;
    n = body.size();
    if (n == 0) return;
    if (n >= 5)
      for (int i = 0; i <= n - 5; i++) exp_d.push_back({body[i], i == 0, i == n - 5});
    if (n >= 4) begin
      fcs = {body[n-1], body[n-2], body[n-3], body[n-4]};
      s.crc = (crc32_std(body, n - 4) != fcs);
    end else begin
      s.crc = ((~crc32_std(body, n)) != 32'hDEBB20E3);
    end
    s.len = (n > 65535) ? 16'hFFFF : 16'(n);
    s.le  = (n < 64) || (n > 1518);
    s.phy = (er_idx >= 0) && (er_idx < n);
    exp_s.push_back(s);
  endtask

  task automatic drive(input logic [7:0] d, input logic e, input logic er);
    bgmii_rxd = d; bgmii_rxe = e; bgmii_rxer = er;
    @(posedge rx_clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(8'h00, 1'b0, 1'b0);
  endtask

  // Gap cycles carry rxer=1 with rxe=0, which must be ignored.
  task automatic send(input bq_t body, input int npre, input int er_idx, input int gap);
    model_push(body, er_idx);
    repeat (npre) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < body.size(); i++) drive(body[i], 1'b1, i == er_idx);
    repeat (gap) drive(8'h0F, 1'b0, 1'b1);
  endtask

  // Compare every output byte and status strobe against the model queues.
  always @(negedge rx_clk) begin
    dexp_t e;
    sexp_t s;
    if (rst_b === 1'b1) begin
      if (rx_valid) begin
        n_data++;
        if (exp_d.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_byte: got %0h expected no output", rx_data);
        end else begin
          e = exp_d.pop_front();
          chk("rx_data", {24'h0, rx_data}, {24'h0, e.d});
          chk("rx_sof", {31'h0, rx_sof}, {31'h0, e.sof});
          chk("rx_eof", {31'h0, rx_eof}, {31'h0, e.eof});
        end
      end
      if (rx_stat_valid) begin
        n_stat++;
        last_len = rx_len; last_crc = rx_crc_err; last_le = rx_len_err; last_phy = rx_phy_err;
        if (exp_s.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_stat: got len %0d expected no status", rx_len);
        end else begin
          s = exp_s.pop_front();
          chk("rx_len", {16'h0, rx_len}, {16'h0, s.len});
          chk("rx_crc_err", {31'h0, rx_crc_err}, {31'h0, s.crc});
          chk("rx_len_err", {31'h0, rx_len_err}, {31'h0, s.le});
          chk("rx_phy_err", {31'h0, rx_phy_err}, {31'h0, s.phy});
        end
      end
    end
  end

  initial begin
    bq_t p1, f1, f2, q, big, pin;
    int snap_s, snap_d;
    rst_b = 1'b0; bgmii_rxd = 8'h00; bgmii_rxe = 1'b0; bgmii_rxer = 1'b0;
    #1;
    chk("reset_valid", {31'h0, rx_valid}, 32'h0);
    chk("reset_stat", {31'h0, rx_stat_valid}, 32'h0);
    chk("reset_len", {16'h0, rx_len}, 32'h0);
    chk("reset_errs", {29'h0, rx_crc_err, rx_len_err, rx_phy_err}, 32'h0);
    repeat (3) @(posedge rx_clk);
    #1 rst_b = 1'b1;

    // Pin the model CRC with the well-known check value of "123456789".
    for (int i = 0; i < 9; i++) pin.push_back(8'h31 + 8'(i));
    chk("crc_model_pin", crc32_std(pin, 9), 32'hCBF43926);

    // 1: good 64-byte frame
    for (int i = 0; i < 60; i++) p1.push_back(8'(i));
    f1 = mk_frame(p1);
    n_data = 0;
    send(f1, 7, -1, 1); idle(3);
    chk("t1_count", n_data, 60);
    chk("t1_len", {16'h0, last_len}, 32'd64);
    chk("t1_errs", {29'h0, last_crc, last_le, last_phy}, 32'h0);

    // 2: corrupted FCS
    f2 = f1; f2[60] = f2[60] ^ 8'h01;
    send(f2, 7, -1, 1); idle(3);
    chk("t2_crc_err", {31'h0, last_crc}, 32'h1);
    chk("t2_len", {16'h0, last_len}, 32'd64);

    // 3: runt of 3 bytes
    q = '{8'hAA, 8'hBB, 8'hCC};
    n_data = 0;
    send(q, 1, -1, 1); idle(3);
    chk("t3_count", n_data, 0);
    chk("t3_len", {16'h0, last_len}, 32'd3);
    chk("t3_len_err", {31'h0, last_le}, 32'h1);

    // 4: phy error on payload byte 10, then a bad-SFD frame dropped
    send(f1, 7, 10, 1); idle(3);
    chk("t4_phy_err", {31'h0, last_phy}, 32'h1);
    snap_s = n_stat; snap_d = n_data;
    drive(8'h55, 1'b1, 1'b0); drive(8'h55, 1'b1, 1'b0); drive(8'h5D, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) drive(8'(i), 1'b1, 1'b0);
    idle(3);
    chk("t4_drop_stat", n_stat, snap_s);
    chk("t4_drop_data", n_data, snap_d);

    // zero-length frame: SFD then rxe falls -> nothing
    q.delete();
    snap_s = n_stat;
    send(q, 1, -1, 1); idle(3);
    chk("t4_zero_len", n_stat, snap_s);

    // 5-byte frame with no preamble: sof and eof on one byte
    q = '{8'h42};
    send(mk_frame(q), 0, -1, 1); idle(3);
    chk("t4_5b_len", {16'h0, last_len}, 32'd5);

    // length boundaries 63 and 1518
    q.delete(); for (int i = 0; i < 59; i++) q.push_back(8'(i * 3));
    send(mk_frame(q), 7, -1, 1); idle(3);
    chk("t4_63_len_err", {31'h0, last_le}, 32'h1);
    q.delete(); for (int i = 0; i < 1514; i++) q.push_back(8'(i ^ 7));
    send(mk_frame(q), 7, -1, 1); idle(3);
    chk("t4_1518_len_err", {31'h0, last_le}, 32'h0);

    // 5: oversize frame, 1-cycle gap, then frame 1 back-to-back
    for (int i = 0; i < 1515; i++) big.push_back(8'(i));
    n_data = 0;
    send(mk_frame(big), 7, -1, 1);
    send(f1, 7, -1, 1); idle(3);
    chk("t5_count", n_data, 1515 + 60);
    chk("t5_len_last", {16'h0, last_len}, 32'd64);

    // 6: reset during payload byte 20
    for (int i = 0; i <= 14; i++) exp_d.push_back({f1[i], i == 0, 1'b0});
    repeat (7) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) drive(f1[i], 1'b1, 1'b0);
    @(negedge rx_clk); #1;
    rst_b = 1'b0; bgmii_rxe = 1'b0;
    snap_s = n_stat;
    #1;
    chk("t6_rst_valid", {31'h0, rx_valid}, 32'h0);
    chk("t6_rst_data", {24'h0, rx_data}, 32'h0);
    chk("t6_rst_len", {16'h0, rx_len}, 32'h0);
    repeat (2) @(posedge rx_clk);
    #1 rst_b = 1'b1;
    idle(3);
    chk("t6_no_stat", n_stat, snap_s);
    send(f1, 7, -1, 1); idle(3);
    chk("t6_after_len", {16'h0, last_len}, 32'd64);
    chk("t6_after_crc", {31'h0, last_crc}, 32'h0);

    idle(10);
    chk("leftover_data", exp_d.size(), 0);
    chk("leftover_stat", exp_s.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
